// File: rtl/wt_mem_responder.sv
// rtl/wt_mem_responder.sv - memory-side responder for the write-through L1 request/return interface
// Optional AMO datapath enabled by defining WT_MEM_RESP_AMO_EN.
module wt_mem_responder #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned TidWidth  = 2,
  parameter int unsigned MemWords  = 1024,
  parameter int unsigned LineWords = 2,
  parameter int unsigned Latency   = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stall_i,
  input  logic                    icache_data_req_i,
  output logic                    icache_data_ack_o,
  input  logic [AddrWidth-1:0]    icache_paddr_i,
  input  logic [TidWidth-1:0]     icache_tid_i,
  output logic                    icache_rtrn_vld_o,
  output logic [TidWidth-1:0]     icache_rtrn_tid_o,
  output logic [64*LineWords-1:0] icache_rtrn_data_o,
  input  logic                    dcache_data_req_i,
  output logic                    dcache_data_ack_o,
  input  logic [1:0]              dcache_rtype_i,
  input  logic [AddrWidth-1:0]    dcache_paddr_i,
  input  logic [TidWidth-1:0]     dcache_tid_i,
  input  logic [7:0]              dcache_be_i,
  input  logic [63:0]             dcache_wdata_i,
  input  logic                    dcache_amo_op_i,
  output logic                    dcache_rtrn_vld_o,
  output logic [1:0]              dcache_rtrn_type_o,
  output logic [TidWidth-1:0]     dcache_rtrn_tid_o,
  output logic [64*LineWords-1:0] dcache_rtrn_data_o
);
  localparam int unsigned IdxW  = $clog2(MemWords);
  localparam int unsigned DataW = 64 * LineWords;
  localparam int unsigned Last  = Latency - 1;
  localparam logic [1:0] RtLoad = 2'd0, RtStore = 2'd1, RtAmo = 2'd2;

  logic rr_q;
  logic i_req, d_req, i_gnt, d_gnt;

  // Reset also gates the acks so nothing is accepted while it is held.
  assign i_req = icache_data_req_i & ~stall_i & ~rst_i;
  assign d_req = dcache_data_req_i & ~stall_i & ~rst_i;
  assign i_gnt = i_req & (~d_req | ~rr_q);
  assign d_gnt = d_req & (~i_req | rr_q);
  assign icache_data_ack_o = i_gnt;
  assign dcache_data_ack_o = d_gnt;

  logic [IdxW-1:0] i_idx, d_idx, acc_idx, line_base;
  assign i_idx     = icache_paddr_i[3 +: IdxW];
  assign d_idx     = dcache_paddr_i[3 +: IdxW];
  assign acc_idx   = d_gnt ? d_idx : i_idx;
  assign line_base = acc_idx & ~IdxW'(LineWords - 1);

  logic [63:0]      mem [MemWords];
  logic [63:0]      old_word, new_word;
  logic [DataW-1:0] line_rd, rsp_data;
  logic [1:0]       rsp_type;
  logic             mem_we;

  always_comb begin
    line_rd = '0;
    for (int k = 0; k < int'(LineWords); k++) begin
      line_rd[64*k +: 64] = mem[line_base + IdxW'(k)];
    end
  end

  assign old_word = mem[d_idx];

  always_comb begin
    new_word = old_word;
    mem_we   = 1'b0;
    rsp_type = RtLoad;
    rsp_data = '0;
    if (d_gnt) begin
      rsp_type = dcache_rtype_i;
      case (dcache_rtype_i)
        RtLoad: rsp_data = line_rd;
        RtStore: begin
          mem_we = 1'b1;
          for (int b = 0; b < 8; b++) begin
            if (dcache_be_i[b]) new_word[8*b +: 8] = dcache_wdata_i[8*b +: 8];
          end
        end
        RtAmo: begin
`ifdef WT_MEM_RESP_AMO_EN
          mem_we         = 1'b1;
          new_word       = dcache_amo_op_i ? old_word + dcache_wdata_i : dcache_wdata_i;
          rsp_data[63:0] = old_word;
`endif
        end
        default: rsp_type = RtStore;
      endcase
    end else if (i_gnt) begin
      rsp_data = line_rd;
    end
  end

  // Write lands on the accept edge, so the next accepted request reads it.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[d_idx] <= new_word;
  end

  logic [Latency-1:0]  vld_q, port_q;
  logic [1:0]          type_q [Latency];
  logic [TidWidth-1:0] tid_q  [Latency];
  logic [DataW-1:0]    data_q [Latency];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= 1'b0;
      vld_q  <= '0;
      port_q <= '0;
      for (int s = 0; s < int'(Latency); s++) begin
        type_q[s] <= '0;
        tid_q[s]  <= '0;
        data_q[s] <= '0;
      end
    end else begin
      if (i_req & d_req) rr_q <= ~rr_q;
      vld_q[0]  <= i_gnt | d_gnt;
      port_q[0] <= d_gnt;
      type_q[0] <= rsp_type;
      tid_q[0]  <= d_gnt ? dcache_tid_i : icache_tid_i;
      data_q[0] <= rsp_data;
      for (int s = 1; s < int'(Latency); s++) begin
        vld_q[s]  <= vld_q[s-1];
        port_q[s] <= port_q[s-1];
        type_q[s] <= type_q[s-1];
        tid_q[s]  <= tid_q[s-1];
        data_q[s] <= data_q[s-1];
      end
    end
  end

  assign icache_rtrn_vld_o  = vld_q[Last] & ~port_q[Last];
  assign icache_rtrn_tid_o  = tid_q[Last];
  assign icache_rtrn_data_o = data_q[Last];
  assign dcache_rtrn_vld_o  = vld_q[Last] & port_q[Last];
  assign dcache_rtrn_type_o = type_q[Last];
  assign dcache_rtrn_tid_o  = tid_q[Last];
  assign dcache_rtrn_data_o = data_q[Last];

  logic unused_bits;
  assign unused_bits = ^{icache_paddr_i[AddrWidth-1:3+IdxW], icache_paddr_i[2:0],
                         dcache_paddr_i[AddrWidth-1:3+IdxW], dcache_paddr_i[2:0]
`ifndef WT_MEM_RESP_AMO_EN
                         , dcache_amo_op_i
`endif
                        };
endmodule
